// File: rtl/uart_cfg_core.sv
// Full-duplex UART core: parametrised TX serialiser and RX deserialiser with optional parity,
// one or two stop bits and an internal loopback path from the TX line into the RX synchroniser.
module uart_cfg_core #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_Rst_L,
    input  logic                 i_TX_Data_Valid,
    input  logic [DATA_BITS-1:0] i_TX_Byte,
    output logic                 o_TX_Active,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Done,
    input  logic                 i_RX_Serial,
    input  logic                 i_Loopback,
    output logic                 o_RX_Data_Valid,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_RX_Parity_Err,
    output logic                 o_RX_Frame_Err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] DATA_LAST    = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST    = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD      = (PARITY_ODD != 0);
    localparam logic             PAR_ON       = (PARITY_EN != 0);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
        return (^data) ^ PAR_ODD;
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_PARITY  = 3'd3,
        RX_STOP    = 3'd4,
        RX_CLEANUP = 3'd5
    } rx_state_t;

    tx_state_t            tx_state_r;
    logic [CNT_W-1:0]     tx_cnt_r;
    logic [IDX_W-1:0]     tx_idx_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic                 tx_line_r;
    logic                 tx_active_r;
    logic                 tx_done_r;

    rx_state_t            rx_state_r;
    logic [CNT_W-1:0]     rx_cnt_r;
    logic [IDX_W-1:0]     rx_idx_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_par_pend_r;
    logic                 rx_frm_pend_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic                 rx_valid_r;
    logic [DATA_BITS-1:0] rx_byte_r;
    logic                 rx_perr_r;
    logic                 rx_ferr_r;
    logic                 rx_in_s;

    assign rx_in_s         = i_Loopback ? tx_line_r : i_RX_Serial;
    assign o_TX_Serial     = tx_line_r | i_Loopback;
    assign o_TX_Active     = tx_active_r;
    assign o_TX_Done       = tx_done_r;
    assign o_RX_Data_Valid = rx_valid_r;
    assign o_RX_Byte       = rx_byte_r;
    assign o_RX_Parity_Err = rx_perr_r;
    assign o_RX_Frame_Err  = rx_ferr_r;

    // TX FSM: the last stop bit ends one cycle early into IDLE so Done/idle overlap its final clock,
    // letting a valid in the Done cycle start the next frame with no gap.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_state_r  <= TX_IDLE;
            tx_cnt_r    <= '0;
            tx_idx_r    <= '0;
            tx_shift_r  <= '0;
            tx_par_r    <= 1'b0;
            tx_line_r   <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (tx_state_r)
                TX_IDLE: begin
                    tx_line_r <= 1'b1;
                    tx_cnt_r  <= '0;
                    tx_idx_r  <= '0;
                    if (i_TX_Data_Valid) begin
                        tx_shift_r  <= i_TX_Byte;
                        tx_par_r    <= parity_of(i_TX_Byte);
                        tx_line_r   <= 1'b0;
                        tx_active_r <= 1'b1;
                        tx_state_r  <= TX_START;
                    end else begin
                        tx_active_r <= 1'b0;
                    end
                end
                TX_START, TX_DATA: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= '0;
                        if (tx_state_r == TX_DATA && tx_idx_r == DATA_LAST) begin
                            tx_idx_r   <= '0;
                            tx_line_r  <= PAR_ON ? tx_par_r : 1'b1;
                            tx_state_r <= PAR_ON ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_idx_r   <= (tx_state_r == TX_DATA) ? tx_idx_r + IDX_ONE : '0;
                            tx_line_r  <= tx_shift_r[0];
                            tx_shift_r <= tx_shift_r >> 1;
                            tx_state_r <= TX_DATA;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= '0;
                        tx_idx_r   <= '0;
                        tx_line_r  <= 1'b1;
                        tx_state_r <= TX_STOP;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    tx_line_r <= 1'b1;
                    if (tx_idx_r == STOP_LAST && tx_cnt_r == CNT_PRE_LAST) begin
                        tx_cnt_r    <= '0;
                        tx_idx_r    <= '0;
                        tx_done_r   <= 1'b1;
                        tx_active_r <= 1'b0;
                        tx_state_r  <= TX_IDLE;
                    end else if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= '0;
                        tx_idx_r <= tx_idx_r + IDX_ONE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r  <= TX_IDLE;
                    tx_line_r   <= 1'b1;
                    tx_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus one delayed copy used as the falling-edge reference.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in_s;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX FSM: IDLE arms only on a true 1->0 edge, so a line stuck low after a bad stop bit stays quiet.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_state_r    <= RX_IDLE;
            rx_cnt_r      <= '0;
            rx_idx_r      <= '0;
            rx_shift_r    <= '0;
            rx_par_pend_r <= 1'b0;
            rx_frm_pend_r <= 1'b0;
            rx_valid_r    <= 1'b0;
            rx_byte_r     <= '0;
            rx_perr_r     <= 1'b0;
            rx_ferr_r     <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    rx_idx_r <= '0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_HALF) begin
                        rx_cnt_r      <= '0;
                        rx_par_pend_r <= 1'b0;
                        rx_frm_pend_r <= 1'b0;
                        rx_state_r    <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                        if (rx_idx_r == DATA_LAST) begin
                            rx_idx_r   <= '0;
                            rx_state_r <= PAR_ON ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + IDX_ONE;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r      <= '0;
                        rx_par_pend_r <= rx_sync_r ^ parity_of(rx_shift_r);
                        rx_state_r    <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r <= '0;
                        if (!rx_sync_r) begin
                            rx_frm_pend_r <= 1'b1;
                        end else begin
                            rx_frm_pend_r <= rx_frm_pend_r;
                        end
                        if (rx_idx_r == STOP_LAST) begin
                            rx_idx_r   <= '0;
                            rx_state_r <= RX_CLEANUP;
                        end else begin
                            rx_idx_r <= rx_idx_r + IDX_ONE;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_CLEANUP: begin
                    rx_valid_r <= 1'b1;
                    rx_byte_r  <= rx_shift_r;
                    rx_perr_r  <= rx_par_pend_r;
                    rx_ferr_r  <= rx_frm_pend_r;
                    rx_state_r <= RX_IDLE;
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: instance A is 8N1, instance B is 8 data + odd parity + 2 stop bits.
module tb_uart_cfg_core;
    localparam int CPB = 8;
    localparam int NA  = 10;
    localparam int NB  = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_tx_valid, a_tx_active, a_tx_serial, a_tx_done, a_rx_serial, a_loop;
    logic       a_rx_valid, a_perr, a_ferr;
    logic [7:0] a_tx_byte, a_rx_byte;
    logic       b_tx_valid, b_tx_active, b_tx_serial, b_tx_done, b_rx_serial, b_loop;
    logic       b_rx_valid, b_perr, b_ferr;
    logic [7:0] b_tx_byte, b_rx_byte;

    uart_cfg_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .i_Rst_L(rst_n), .i_TX_Data_Valid(a_tx_valid), .i_TX_Byte(a_tx_byte),
        .o_TX_Active(a_tx_active), .o_TX_Serial(a_tx_serial), .o_TX_Done(a_tx_done),
        .i_RX_Serial(a_rx_serial), .i_Loopback(a_loop), .o_RX_Data_Valid(a_rx_valid),
        .o_RX_Byte(a_rx_byte), .o_RX_Parity_Err(a_perr), .o_RX_Frame_Err(a_ferr));

    uart_cfg_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .i_Rst_L(rst_n), .i_TX_Data_Valid(b_tx_valid), .i_TX_Byte(b_tx_byte),
        .o_TX_Active(b_tx_active), .o_TX_Serial(b_tx_serial), .o_TX_Done(b_tx_done),
        .i_RX_Serial(b_rx_serial), .i_Loopback(b_loop), .o_RX_Data_Valid(b_rx_valid),
        .o_RX_Byte(b_rx_byte), .o_RX_Parity_Err(b_perr), .o_RX_Frame_Err(b_ferr));

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_rec_t;

    typedef struct {
        logic [7:0] data;
        bit         flip_par;
        bit         zero_s1;
        bit         zero_s2;
        logic [7:0] exp_byte;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    rx_rec_t    a_q[$];
    rx_rec_t    b_q[$];
    logic [7:0] burst_q[$];
    int         a_done_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    // Output monitors: record every RX delivery and every TX Done pulse.
    always @(negedge clk) begin
        if (a_rx_valid === 1'b1) a_q.push_back(rx_rec_t'{a_rx_byte, a_perr, a_ferr});
        if (b_rx_valid === 1'b1) b_q.push_back(rx_rec_t'{b_rx_byte, b_perr, b_ferr});
        if (a_tx_done === 1'b1) a_done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame: bit i is the line level during bit period i; stop bits default to 1.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit pen, input bit podd);
        logic [15:0] f;
        f = 16'hFFFF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (pen) f[9] = (^d) ^ podd;
        return f;
    endfunction

    task automatic tx_check(input int inst, input logic [7:0] d, input string tag, output logic [15:0] obs);
        logic [15:0] f;
        int n, bad, dcnt, dat;
        logic line, dn;
        f = (inst == 0) ? frame_bits(d, 1'b0, 1'b0) : frame_bits(d, 1'b1, 1'b1);
        n = (inst == 0) ? NA : NB;
        obs = 16'hFFFF; bad = 0; dcnt = 0; dat = -1;
        @(negedge clk);
        if (inst == 0) begin a_tx_valid = 1'b1; a_tx_byte = d; end
        else begin b_tx_valid = 1'b1; b_tx_byte = d; end
        @(negedge clk);
        a_tx_valid = 1'b0; b_tx_valid = 1'b0;
        check({tag, "_active_after_accept"}, (inst == 0) ? a_tx_active : b_tx_active, 1'b1);
        for (int c = 0; c < n * CPB; c++) begin
            line = (inst == 0) ? a_tx_serial : b_tx_serial;
            dn   = (inst == 0) ? a_tx_done : b_tx_done;
            if (line !== f[c / CPB]) bad++;
            if (c % CPB == CPB / 2) obs[c / CPB] = line;
            if (dn === 1'b1) begin dcnt++; dat = c; end
            @(negedge clk);
        end
        check({tag, "_wrong_line_cycles"}, bad, 0);
        check({tag, "_done_count"}, dcnt, 1);
        check({tag, "_done_cycle"}, dat, n * CPB - 1);
        check({tag, "_active_after_frame"}, (inst == 0) ? a_tx_active : b_tx_active, 1'b0);
    endtask

    task automatic drive_frame(input int inst, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst == 0) a_rx_serial = f[i]; else b_rx_serial = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic expect_rx(input int inst, input logic [7:0] eb, input logic ep, input logic ef, input string tag);
        int waited;
        rx_rec_t rec;
        waited = 0;
        while (((inst == 0) ? a_q.size() : b_q.size()) == 0 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
        end
        if (((inst == 0) ? a_q.size() : b_q.size()) == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no o_RX_Data_Valid within %0d cycles", tag, 4 * CPB);
        end else begin
            if (inst == 0) rec = a_q.pop_front(); else rec = b_q.pop_front();
            check({tag, "_byte"}, rec.data, eb);
            check({tag, "_parity_err"}, rec.perr, ep);
            check({tag, "_frame_err"}, rec.ferr, ef);
            check({tag, "_extra_valid"}, (inst == 0) ? a_q.size() : b_q.size(), 0);
        end
    endtask

    task automatic loop_burst(input string tag);
        int n, idx, cyc, dcnt, last_done, ser_bad;
        rx_rec_t rec;
        n = burst_q.size();
        a_q.delete();
        a_loop = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b1; a_tx_byte = burst_q[0];
        @(negedge clk);
        idx = 1; cyc = 0; dcnt = 0; last_done = -1; ser_bad = 0;
        while (dcnt < n && cyc < n * NA * CPB + 4 * CPB) begin
            a_tx_valid = 1'b0;
            if (a_tx_serial !== 1'b1) ser_bad++;
            if (a_tx_done === 1'b1) begin
                dcnt++;
                last_done = cyc;
                if (idx < n) begin
                    a_tx_valid = 1'b1; a_tx_byte = burst_q[idx]; idx++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        a_tx_valid = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check({tag, "_done_count"}, dcnt, n);
        check({tag, "_no_gap_last_done"}, last_done, n * NA * CPB - 1);
        check({tag, "_serial_forced_high"}, ser_bad, 0);
        check({tag, "_rx_count"}, a_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (a_q.size() > 0) begin
                rec = a_q.pop_front();
                check({tag, "_rx_byte"}, rec.data, burst_q[i]);
                check({tag, "_rx_flags"}, {rec.perr, rec.ferr}, 2'b00);
            end
        end
        a_loop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rx_vec_t     vecs[6];
        logic [15:0] f, obs;
        logic [7:0]  d;
        bit          fl, z1, z2;
        int          done_before;

        vecs[0] = '{8'h07, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{8'hA3, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        a_tx_valid = 1'b0; a_tx_byte = 8'h00; a_rx_serial = 1'b1; a_loop = 1'b0;
        b_tx_valid = 1'b0; b_tx_byte = 8'h00; b_rx_serial = 1'b1; b_loop = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a_tx_serial", a_tx_serial, 1'b1);
        check("reset_a_tx_active", a_tx_active, 1'b0);
        check("reset_a_tx_done", a_tx_done, 1'b0);
        check("reset_a_rx_valid", a_rx_valid, 1'b0);
        check("reset_a_rx_byte", a_rx_byte, 8'h00);
        check("reset_b_flags", {b_perr, b_ferr}, 2'b00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_check(0, 8'hA5, "tx_a5", obs);
        check("tx_a5_bit_pattern", obs[9:0], 10'b1101001010);
        tx_check(1, 8'h07, "tx_par07", obs);
        check("tx_par07_parity_bit", obs[9], 1'b0);
        for (int k = 0; k < 3; k++) tx_check(0, 8'($urandom_range(0, 255)), "tx_rand", obs);

        // Reset mid-frame while sending zeros: line must snap high before any clock edge.
        @(negedge clk); a_tx_valid = 1'b1; a_tx_byte = 8'h00;
        @(negedge clk); a_tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_line_before", a_tx_serial, 1'b0);
        done_before = a_done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async_line", a_tx_serial, 1'b1);
        check("midrst_async_active", a_tx_active, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (NA * CPB) @(negedge clk);
        check("midrst_no_done", a_done_cnt, done_before);
        check("midrst_line_idle", a_tx_serial, 1'b1);

        burst_q = '{8'h00, 8'hFF, 8'h3C};
        loop_burst("loop_fixed");
        for (int k = 0; k < 2; k++) begin
            burst_q.delete();
            repeat ($urandom_range(2, 4)) burst_q.push_back(8'($urandom_range(0, 255)));
            loop_burst("loop_rand");
        end

        // Glitch reject on A, then a clean 0x81 frame.
        a_q.delete();
        a_rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        a_rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_valid", a_q.size(), 0);
        drive_frame(0, frame_bits(8'h81, 1'b0, 1'b0), NA);
        a_rx_serial = 1'b1;
        expect_rx(0, 8'h81, 1'b0, 1'b0, "glitch_then_81");

        b_q.delete();
        for (int v = 0; v < 6; v++) begin
            f = frame_bits(vecs[v].data, 1'b1, 1'b1);
            if (vecs[v].flip_par) f[9] = ~f[9];
            if (vecs[v].zero_s1) f[10] = 1'b0;
            if (vecs[v].zero_s2) f[11] = 1'b0;
            drive_frame(1, f, NB);
            b_rx_serial = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            expect_rx(1, vecs[v].exp_byte, vecs[v].exp_perr, vecs[v].exp_ferr, "rx_table");
        end

        // Break: second stop low on 0x55 and the line held low for several frame times.
        f = frame_bits(8'h55, 1'b1, 1'b1);
        f[11] = 1'b0;
        drive_frame(1, f, NB);
        expect_rx(1, 8'h55, 1'b0, 1'b1, "break_first");
        repeat (5 * NB * CPB) @(negedge clk);
        check("break_no_repeat", b_q.size(), 0);
        b_rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        drive_frame(1, frame_bits(8'h3C, 1'b1, 1'b1), NB);
        b_rx_serial = 1'b1;
        expect_rx(1, 8'h3C, 1'b0, 1'b0, "break_recover");

        for (int k = 0; k < 6; k++) begin
            d  = 8'($urandom_range(0, 255));
            fl = 1'($urandom_range(0, 1));
            z1 = ($urandom_range(0, 3) == 0);
            z2 = ($urandom_range(0, 3) == 0);
            f  = frame_bits(d, 1'b1, 1'b1);
            if (fl) f[9] = ~f[9];
            if (z1) f[10] = 1'b0;
            if (z2) f[11] = 1'b0;
            repeat (2 * CPB) @(negedge clk);
            drive_frame(1, f, NB);
            b_rx_serial = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            expect_rx(1, d, f[9] ^ ((^d) ^ 1'b1), z1 | z2, "rx_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
